uart_tx_arb: RTL and testbench
==============================

UART_TX_ARB -- requirements
Module: uart_tx_arb

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, giving the number of requesters (2..4).
REQ-002 The block SHALL have parameter HOLD_TIMEOUT, default 65535, giving the idle cycles allowed mid-packet before the grant is revoked.
REQ-003 Port clk  input  1  single system clock; all logic on posedge clk.
REQ-004 Port rst_n  input  1  asynchronous active-low reset.
REQ-005 Port req_valid  input  N_REQ  per-requester byte-available flag.
REQ-006 Port req_data  input  8*N_REQ  per-requester byte; requester i occupies bits [8i+7:8i].
REQ-007 Port req_last  input  N_REQ  marks the offered byte as the last byte of its packet.
REQ-008 Port req_ready  output  N_REQ  one-cycle accept strobe; the byte is taken when req_valid[i] and req_ready[i] are both 1.
REQ-009 Port grant  output  N_REQ  one-hot owner of the transmitter; all zero when unowned.
REQ-010 Port tx_din  output  8  byte to the transmitter; held stable from ISSUE until the next capture.
REQ-011 Port tx_wen  output  1  write strobe to the transmitter.
REQ-012 Port tx_ready  input  1  transmitter idle flag.
REQ-013 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-014 The FSM SHALL have the states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH and HOLD.
REQ-015 IDLE: when any req_valid=1 and tx_ready=1, the FSM SHALL select the first valid requester at or after rr_ptr (wrapping N_REQ-1 to 0), as follows.
- Assert req_ready[sel] combinationally in the same cycle.
- Register the byte into tx_din and req_last into last_q.
- Set grant to one-hot sel.
- Go to ISSUE.
REQ-016 ISSUE SHALL drive tx_wen=1 for exactly one cycle, then go to WAIT_LOW.
REQ-017 WAIT_LOW SHALL go to WAIT_HIGH when tx_ready=0; if tx_ready stays 1 for 4 cycles, the byte counts as accepted and the FSM SHALL go to WAIT_HIGH.
REQ-018 WAIT_HIGH: when tx_ready=1, the FSM SHALL go to IDLE if last_q=1, otherwise to HOLD.
REQ-019 On leaving WAIT_HIGH toward IDLE, the FSM SHALL clear grant and set rr_ptr to (owner+1) mod N_REQ.
REQ-020 HOLD: only the granted requester is eligible. When its req_valid=1, the FSM SHALL capture the byte as in REQ-015 and go to ISSUE; all other req_ready SHALL stay 0.
REQ-021 HOLD SHALL count consecutive cycles without the owner's req_valid. At HOLD_TIMEOUT, the FSM SHALL clear grant, advance rr_ptr as in REQ-019 and go to IDLE.
REQ-022 The block SHALL allow at most one req_ready bit high per cycle, and req_ready SHALL never be high outside IDLE or HOLD.
REQ-023 tx_wen SHALL never assert unless the previous byte's WAIT_HIGH has completed; there are no back-to-back strobes.
REQ-024 A requester dropping req_valid while granted SHALL keep its grant (see REQ-021). A mid-packet byte from a non-owner SHALL wait.
REQ-025 Minimum latency SHALL be 1 cycle from capture to tx_wen.

Reset
REQ-026 While rst_n=0, the block SHALL hold the following values: state=IDLE, grant=0, req_ready=0, tx_wen=0, tx_din=8'h00, busy=0, rr_ptr=0, last_q=0, timeout counter=0.
REQ-027 Reset asserted mid-packet SHALL abort without further tx_wen. The first post-reset arbitration SHALL start from requester 0.

Structure
REQ-028 A shared package uart_pkg SHALL hold the FSM state enum, the WAIT_LOW guard constant (4) and the default HOLD_TIMEOUT.
REQ-029 Round-robin selection SHALL be a sub-module rr_pick (inputs: valid vector, pointer; outputs: one-hot select and any-valid).

Verification
REQ-030 Single byte: req0 offers 8'h41 with last=1, and tx_ready pulses low 2 cycles after tx_wen. Required response: req_ready[0] for 1 cycle, tx_wen 1 cycle later with tx_din=8'h41, then back to IDLE with grant=0.
REQ-031 Packet lock: req0 sends 8'h31,8'h32,8'h0A (last on the third byte) while req1 holds 8'h55 valid throughout. Required response: all three req0 bytes go out before 8'h55, and req_ready[1] stays 0 during the packet.
REQ-032 Fairness: both requesters continuously offer single-byte packets. Required response: grants alternate 0,1,0,1 over 4 packets.
REQ-033 Timeout: with HOLD_TIMEOUT=8, req0 sends one byte with last=0 then drops req_valid. Required response: grant clears after 8 HOLD cycles, and a pending req1 is granted next.
REQ-034 Stuck ready: tx_ready held at 1. Required response: after 4 WAIT_LOW cycles the next byte proceeds, with exactly one tx_wen per byte.
REQ-035 Reset in WAIT_HIGH: rst_n pulsed low. Required response: all outputs take their REQ-026 values asynchronously, and no tx_wen occurs until a new request.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and timing constants for the UART transmit arbiter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, HOLD} state_t;
  localparam int WL_GUARD = 4;
  localparam int HOLD_TIMEOUT_DEF = 65535;
endpackage

// File: rtl/uart_tx_arb_if.sv
// uart_tx_arb_if: requester and transmitter signals between the arbiter and its neighbours
interface uart_tx_arb_if #(parameter int N_REQ = 2);
  logic [N_REQ-1:0] req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0] req_last;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ-1:0] grant;
  logic [7:0] tx_din;
  logic tx_wen;
  logic tx_ready;
  logic busy;
  modport slave (input req_valid, req_data, req_last, tx_ready, output req_ready, grant, tx_din, tx_wen, busy);
  modport master (output req_valid, req_data, req_last, tx_ready, input req_ready, grant, tx_din, tx_wen, busy);
endinterface

// File: rtl/uart_tx_arb_rr_pick.sv
// rr_pick: one-hot select of the first valid requester at or after ptr, wrapping
module rr_pick #(
  parameter int N = 2,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  valid,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  sel,
  output logic          any
);
  logic [PW-1:0] idx;
  // walk offsets from farthest to nearest so the nearest valid one wins
  always_comb begin
    sel = '0;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % N);
      if (valid[idx]) sel = N'(1) << idx;
    end
  end
  assign any = |valid;
endmodule

// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin, packet-locked arbiter feeding bytes from N requesters to one UART transmitter
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int HOLD_TIMEOUT = HOLD_TIMEOUT_DEF
) (
  input logic clk,
  input logic rst_n,
  uart_tx_arb_if.slave bus
);
  localparam int PW = $clog2(N_REQ);
  localparam int HW = $clog2(HOLD_TIMEOUT + 1);
  localparam int CW = $clog2(WL_GUARD);
  state_t state;
  logic [PW-1:0] rr_ptr, own, sel_idx, cap_idx, nxt_ptr;
  logic [N_REQ-1:0] sel;
  logic any, last_q, cap_idle, cap_hold;
  logic [CW-1:0] wl_cnt;
  logic [HW-1:0] hold_cnt;
  rr_pick #(.N(N_REQ)) u_pick (.valid(bus.req_valid), .ptr(rr_ptr), .sel(sel), .any(any));
  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < N_REQ; i++) if (sel[i]) sel_idx = PW'(i);
  end
  // a byte is taken either by fresh arbitration or by the owner continuing its packet
  assign cap_idle = state == IDLE && bus.tx_ready && any;
  assign cap_hold = state == HOLD && bus.req_valid[own];
  assign cap_idx = cap_idle ? sel_idx : own;
  assign nxt_ptr = own == PW'(N_REQ - 1) ? '0 : own + PW'(1);
  assign bus.req_ready = cap_idle ? sel : cap_hold ? bus.grant : '0;
  assign bus.busy = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      bus.grant <= '0;
      bus.tx_din <= '0;
      bus.tx_wen <= 1'b0;
      last_q <= 1'b0;
      rr_ptr <= '0;
      own <= '0;
      wl_cnt <= '0;
      hold_cnt <= '0;
    end else begin
      bus.tx_wen <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (cap_idle || cap_hold) begin
            state <= ISSUE;
            bus.tx_wen <= 1'b1;
            bus.tx_din <= bus.req_data[{cap_idx, 3'b000} +: 8];
            last_q <= bus.req_last[cap_idx];
            bus.grant <= cap_idle ? sel : bus.grant;
            own <= cap_idx;
            hold_cnt <= '0;
          end else if (state == HOLD && hold_cnt == HW'(HOLD_TIMEOUT - 1)) begin
            state <= IDLE;
            bus.grant <= '0;
            rr_ptr <= nxt_ptr;
          end else if (state == HOLD) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_LOW;
          wl_cnt <= '0;
        end
        // a transmitter that never drops ready is assumed to have taken the byte after the guard
        WAIT_LOW: begin
          if (!bus.tx_ready || wl_cnt == CW'(WL_GUARD - 1)) state <= WAIT_HIGH;
          else wl_cnt <= wl_cnt + 1'b1;
        end
        WAIT_HIGH: begin
          if (bus.tx_ready && last_q) begin
            state <= IDLE;
            bus.grant <= '0;
            rr_ptr <= nxt_ptr;
          end else if (bus.tx_ready) begin
            state <= HOLD;
            hold_cnt <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: scoreboard bench for the UART transmit arbiter with a modelled transmitter and byte sources
module tb_uart_tx_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  uart_tx_arb_if #(.N_REQ(2)) bus ();
  uart_tx_arb #(.N_REQ(2), .HOLD_TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  int total = 0, bad = 0, cyc = 0, wen_n = 0, last_wen = 0, gap = 0;
  logic prev_wen = 1'b0, stuck = 1'b0;
  logic [8:0] q0[$], q1[$];
  logic [9:0] exp_q[$];
  logic [9:0] e;
  logic [8:0] h0, h1;
  logic [1:0] take;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, want);
    end
  endtask
  task automatic drain(input int lim, input string tag);
    for (int i = 0; i < lim && (exp_q.size() != 0 || bus.busy); i++) @(negedge clk);
    chk(tag, exp_q.size(), 0);
  endtask
  task automatic wait_wen(input string tag);
    for (int i = 0; i < 50 && bus.tx_wen !== 1'b1; i++) @(negedge clk);
    chk(tag, bus.tx_wen, 1);
  endtask
  task automatic wait_ready(input logic v, input string tag);
    for (int i = 0; i < 50 && bus.tx_ready !== v; i++) @(negedge clk);
    chk(tag, bus.tx_ready, v);
  endtask
  task automatic do_reset();
    #1 rst_n = 1'b0;
    q0.delete();
    q1.delete();
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask
  // byte sources: pop a byte once it was seen accepted, then present the next one
  initial forever begin
    @(negedge clk);
    take = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    if (take[0] && q0.size() != 0) q0.delete(0);
    if (take[1] && q1.size() != 0) q1.delete(0);
    h0 = q0.size() != 0 ? q0[0] : 9'h0;
    h1 = q1.size() != 0 ? q1[0] : 9'h0;
    bus.req_valid = {q1.size() != 0, q0.size() != 0};
    bus.req_data = {h1[7:0], h0[7:0]};
    bus.req_last = {h1[8], h0[8]};
  end
  // transmitter: ready drops two cycles after each strobe and stays low for three
  initial forever begin
    @(negedge clk);
    if (bus.tx_wen && !stuck) begin
      @(posedge clk);
      #2;
      @(posedge clk);
      #2 bus.tx_ready = 1'b0;
      repeat (3) @(posedge clk);
      #2 bus.tx_ready = 1'b1;
    end
  end
  initial forever begin
    @(negedge clk);
    cyc++;
    if (!rst_n) prev_wen = 1'b0;
    else begin
      chk("rdy_onehot", 32'($onehot0(bus.req_ready)), 1);
      if (bus.grant != 2'b00) chk("rdy_owner", bus.req_ready & ~bus.grant, 0);
      if (bus.tx_wen) begin
        e = 10'h3ff;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        chk("b2b", prev_wen, 0);
        chk("tx_din", bus.tx_din, e[7:0]);
        chk("wen_grant", bus.grant, e[9:8]);
        wen_n++;
        gap = cyc - last_wen;
        last_wen = cyc;
      end
      prev_wen = bus.tx_wen;
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
  initial begin
    int n, w;
    logic found;
    bus.req_valid = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_grant", bus.grant, 0);
    chk("rst_rdy", bus.req_ready, 0);
    chk("rst_wen", bus.tx_wen, 0);
    chk("rst_din", bus.tx_din, 0);
    chk("rst_busy", bus.busy, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    q0.push_back({1'b1, 8'h41});
    exp_q.push_back({2'b01, 8'h41});
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = bus.req_ready[0];
    end
    chk("s_found", found, 1);
    chk("s_rdy", bus.req_ready, 2'b01);
    @(negedge clk);
    chk("s_wen", bus.tx_wen, 1);
    chk("s_rdy_off", bus.req_ready, 0);
    @(negedge clk);
    chk("s_wen_off", bus.tx_wen, 0);
    drain(60, "s_drain");
    chk("s_grant", bus.grant, 0);
    chk("s_busy", bus.busy, 0);
    do_reset();
    q0.push_back({1'b0, 8'h31});
    q0.push_back({1'b0, 8'h32});
    q0.push_back({1'b1, 8'h0A});
    q1.push_back({1'b1, 8'h55});
    exp_q.push_back({2'b01, 8'h31});
    exp_q.push_back({2'b01, 8'h32});
    exp_q.push_back({2'b01, 8'h0A});
    exp_q.push_back({2'b10, 8'h55});
    drain(200, "lock_drain");
    do_reset();
    for (int i = 0; i < 4; i++) begin
      q0.push_back({1'b1, 8'hA0 + 8'(i)});
      q1.push_back({1'b1, 8'hB0 + 8'(i)});
      exp_q.push_back({2'b01, 8'hA0 + 8'(i)});
      exp_q.push_back({2'b10, 8'hB0 + 8'(i)});
    end
    drain(400, "fair_drain");
    do_reset();
    q0.push_back({1'b0, 8'h5A});
    q1.push_back({1'b1, 8'h6B});
    exp_q.push_back({2'b01, 8'h5A});
    exp_q.push_back({2'b10, 8'h6B});
    wait_wen("to_wen");
    wait_ready(1'b0, "to_low");
    wait_ready(1'b1, "to_high");
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.grant != 2'b01) break;
      n++;
    end
    chk("to_hold", n, 8);
    drain(100, "to_drain");
    do_reset();
    stuck = 1'b1;
    bus.tx_ready = 1'b1;
    w = wen_n;
    q0.push_back({1'b0, 8'hA1});
    q0.push_back({1'b1, 8'hA2});
    exp_q.push_back({2'b01, 8'hA1});
    exp_q.push_back({2'b01, 8'hA2});
    drain(100, "stk_drain");
    chk("stk_gap", gap, 7);
    chk("stk_wen", wen_n - w, 2);
    stuck = 1'b0;
    do_reset();
    q0.push_back({1'b1, 8'hC3});
    exp_q.push_back({2'b01, 8'hC3});
    wait_wen("rw_wen");
    wait_ready(1'b0, "rw_low");
    @(negedge clk);
    chk("rw_busy_pre", bus.busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rw_grant", bus.grant, 0);
    chk("rw_rdy", bus.req_ready, 0);
    chk("rw_wen0", bus.tx_wen, 0);
    chk("rw_din", bus.tx_din, 0);
    chk("rw_busy", bus.busy, 0);
    q0.delete();
    q1.delete();
    exp_q.delete();
    w = wen_n;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("rw_nowen", wen_n - w, 0);
    q1.push_back({1'b1, 8'hD1});
    q0.push_back({1'b1, 8'hD0});
    exp_q.push_back({2'b01, 8'hD0});
    exp_q.push_back({2'b10, 8'hD1});
    drain(200, "rw_drain");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
